// File: rtl/audio_wavetable_mixer.sv
// Time-multiplexed wavetable mixer: NUM_VOICES phase-accumulator voices are evaluated
// one per clock once every TICK_DIV clocks and summed into an MSB-aligned unsigned sample.
module audio_wavetable_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int VOL_W      = 4,
  parameter int SAMPLE_W   = 16,
  parameter int TICK_DIV   = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_freq,
  input  logic [1:0]                    cfg_wave,
  input  logic [VOL_W-1:0]              cfg_vol,
  input  logic                          cfg_phase_rst,
  output logic [SAMPLE_W-1:0]           sample_out,
  output logic                          sample_valid,
  output logic                          busy
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = 8 + VOL_W + IDX_W;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VOICES - 1);

  localparam logic [1:0] WAVE_OFF    = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_SQUARE = 2'd2;
  localparam logic [1:0] WAVE_TRI    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t              state_r;
  logic [TICK_W-1:0]   tick_r;
  logic [IDX_W-1:0]    idx_r;
  logic [ACC_W-1:0]    acc_r;

  logic [PHASE_W-1:0]  freq_r  [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_r [NUM_VOICES];
  logic [1:0]          wave_r  [NUM_VOICES];
  logic [VOL_W-1:0]    vol_r   [NUM_VOICES];

  logic                tick_end_s;
  logic [7:0]          p_s;
  logic [7:0]          w_s;
  logic [ACC_W-1:0]    term_s;
  logic [ACC_W-1:0]    acc_next_s;
  logic [SAMPLE_W-1:0] scaled_s;

  assign tick_end_s = (tick_r == TICK_LAST);

  // Waveform lookup and weighted contribution of the voice currently selected by idx_r.
  always_comb begin
    p_s = phase_r[idx_r][PHASE_W-1 -: 8];
    case (wave_r[idx_r])
      WAVE_OFF:    w_s = 8'h00;
      WAVE_SAW:    w_s = p_s;
      WAVE_SQUARE: w_s = p_s[7] ? 8'hFF : 8'h00;
      WAVE_TRI:    w_s = p_s[7] ? {~p_s[6:0], 1'b0} : {p_s[6:0], 1'b0};
      default:     w_s = 8'h00;
    endcase
    term_s     = ACC_W'(w_s) * ACC_W'(vol_r[idx_r]);
    acc_next_s = acc_r + term_s;
  end

  // The accumulator is sized so the full sum never overflows; only alignment is needed here.
  if (ACC_W >= SAMPLE_W) begin : g_trunc
    assign scaled_s = acc_next_s[ACC_W-1 -: SAMPLE_W];
  end else begin : g_pad
    assign scaled_s = {acc_next_s, {(SAMPLE_W - ACC_W){1'b0}}};
  end

  // Tick divider and mix-pass FSM with registered sample/valid/busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      tick_r       <= {TICK_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      sample_out   <= {SAMPLE_W{1'b0}};
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      tick_r <= tick_end_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
      case (state_r)
        ST_IDLE: begin
          sample_valid <= 1'b0;
          if (tick_end_s) begin
            state_r <= ST_ACCUM;
            acc_r   <= {ACC_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + IDX_W'(1);
          // Final voice: publish the completed sum so it is valid alongside the strobe.
          if (idx_r == IDX_LAST) begin
            state_r      <= ST_OUTPUT;
            sample_out   <= scaled_s;
            sample_valid <= 1'b1;
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_OUTPUT: begin
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-voice configuration and phase; a phase clear beats a simultaneous advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_r[v]  <= {PHASE_W{1'b0}};
        phase_r[v] <= {PHASE_W{1'b0}};
        wave_r[v]  <= WAVE_OFF;
        vol_r[v]   <= {VOL_W{1'b0}};
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && (cfg_voice == IDX_W'(v))) begin
          freq_r[v] <= cfg_freq;
          wave_r[v] <= cfg_wave;
          vol_r[v]  <= cfg_vol;
        end
        if (cfg_we && cfg_phase_rst && (cfg_voice == IDX_W'(v))) begin
          phase_r[v] <= {PHASE_W{1'b0}};
        end else if ((state_r == ST_ACCUM) && (idx_r == IDX_W'(v))) begin
          phase_r[v] <= phase_r[v] + freq_r[v];
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_wavetable_mixer.sv
// Scoreboard bench for audio_wavetable_mixer: a cycle-level arithmetic model predicts each
// sample and its arrival cycle; a negedge monitor compares whatever the DUT emits.
module tb_audio_wavetable_mixer;

  localparam int NV = 4;
  localparam int TD = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_freq;
  logic [1:0]  cfg_wave;
  logic [3:0]  cfg_vol;
  logic        cfg_phase_rst;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;

  always #5 clk = ~clk;

  audio_wavetable_mixer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
    .cfg_freq(cfg_freq), .cfg_wave(cfg_wave), .cfg_vol(cfg_vol),
    .cfg_phase_rst(cfg_phase_rst), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy)
  );

  typedef struct { int cyc; int val; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int c = 0;         // driver's cycle index since last reset release
  int mon_cyc = 0;   // monitor's cycle index since last reset release
  bit mon_en = 1'b0;

  int m_freq[NV], m_wave[NV], m_vol[NV], m_phase[NV];
  int m_acc;

  always @(posedge clk) begin
    if (reset) mon_cyc <= 0;
    else       mon_cyc <= mon_cyc + 1;
  end

  function automatic int wave_val(int wave, int phase);
    int p;
    p = (phase >> 8) & 255;
    case (wave)
      1: return p;
      2: return (p >= 128) ? 255 : 0;
      3: return (p < 128) ? 2 * p : 2 * (255 - p);
      default: return 0;
    endcase
  endfunction

  // Model one clock cycle using the inputs currently applied.
  task automatic model_cycle();
    int pos, v;
    exp_t e;
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        m_freq[i] = 0; m_wave[i] = 0; m_vol[i] = 0; m_phase[i] = 0;
      end
      m_acc = 0;
      return;
    end
    pos = c % TD;
    if (c >= TD && pos < NV) begin
      v = pos;
      if (v == 0) m_acc = 0;
      m_acc += wave_val(m_wave[v], m_phase[v]) * m_vol[v];
      m_phase[v] = (m_phase[v] + m_freq[v]) & 16'hFFFF;
      if (v == NV - 1) begin
        e.cyc = c + 1;
        e.val = (m_acc * 4) & 16'hFFFF;
        exp_q.push_back(e);
      end
    end
    if (cfg_we) begin
      m_freq[cfg_voice] = int'(cfg_freq);
      m_wave[cfg_voice] = int'(cfg_wave);
      m_vol[cfg_voice]  = int'(cfg_vol);
      if (cfg_phase_rst) m_phase[cfg_voice] = 0;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    if (reset) c = 0;
    else       c = c + 1;
    reset = 1'b0; cfg_we = 1'b0; cfg_phase_rst = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(int p);
    for (int k = 0; k < 2 * TD && !(c >= TD && (c % TD) == p); k++) tick();
    tests++;
    if (!(c >= TD && (c % TD) == p)) begin
      fails++;
      $display("FAIL wait_pos: cycle %0d, required position %0d", c, p);
    end
  endtask

  task automatic cfg_write(int v, int f, int w, int vol, bit pr);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_freq = 16'(f);
    cfg_wave = 2'(w); cfg_vol = 4'(vol); cfg_phase_rst = pr;
    tick();
  endtask

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (sample_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: cycle %0d sample %0d, required no valid", mon_cyc, sample_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != mon_cyc || mon_e.val != int'(sample_out)) begin
            fails++;
            $display("FAIL sample: got %0d at cycle %0d, required %0d at cycle %0d",
                     sample_out, mon_cyc, mon_e.val, mon_e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= mon_cyc) begin
        tests++; fails++;
        mon_e = exp_q.pop_front();
        $display("FAIL missed_valid: none at cycle %0d, required sample %0d", mon_e.cyc, mon_e.val);
      end
      tests++;
      if (busy !== (mon_cyc >= TD && (mon_cyc % TD) <= NV)) begin
        fails++;
        $display("FAIL busy: got %0b at cycle %0d, required %0b", busy, mon_cyc,
                 (mon_cyc >= TD && (mon_cyc % TD) <= NV));
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_voice = 2'd0; cfg_freq = 16'd0;
    cfg_wave = 2'd0; cfg_vol = 4'd0; cfg_phase_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      tick();
    end
    mon_en = 1'b1;
    check("reset_sample_out", int'(sample_out), 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_busy", int'(busy), 0);

    // Silent mixer: first sample at 516, then every 512 clocks.
    idle(2 * TD + 10);

    // One square voice at half-rate toggling.
    cfg_write(0, 16'h8000, 2, 15, 1'b1);
    idle(4 * TD);

    // All four voices square and phase-aligned: full-scale alternation without overflow.
    wait_pos(100);
    for (int v = 0; v < NV; v++) cfg_write(v, 16'h8000, 2, 15, 1'b1);
    idle(4 * TD);

    // Fresh reset, then a slow triangle crossing its peak.
    wait_pos(200);
    reset = 1'b1;
    tick();
    cfg_write(1, 16'h0800, 3, 1, 1'b0);
    idle(20 * TD);

    // Config write landing on the cycle voice2 is evaluated.
    wait_pos(2);
    cfg_write(2, 16'h1000, 1, 15, 1'b1);
    idle(3 * TD);

    // Reset in the middle of a pass aborts it.
    wait_pos(1);
    reset = 1'b1;
    tick();
    check("midpass_reset_sample_out", int'(sample_out), 0);
    check("midpass_reset_valid", int'(sample_valid), 0);
    check("midpass_reset_busy", int'(busy), 0);
    idle(TD + 10);

    // Randomized writes at random cycles.
    for (int i = 0; i < 12 * TD; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
      end else begin
        tick();
      end
    end

    wait_pos(10);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
